// File: rtl/cnt_seq_pkg.sv
// Shared encodings for the counter sequencer: FSM states and MODE values.
package cnt_seq_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StRun  = 2'd2,
        StDone = 2'd3
    } cnt_state_e;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/cnt_seq_ctrl.sv
// Control FSM for an external loadable up-counter datapath: load, count,
// terminal-count detection, one-shot/periodic sequencing.
module cnt_seq_ctrl
    import cnt_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter string       GSR   = "ENABLED"
) (
    input  logic             CK,
    input  logic             CDN,
    input  logic             START,
    input  logic             STOP,
    input  logic             MODE,
    input  logic             HOLD,
    input  logic [WIDTH-1:0] RELOAD,
    input  logic             CNT_CO,
    output logic [WIDTH-1:0] CNT_D,
    output logic             CNT_SD,
    output logic             CNT_SP,
    output logic             CNT_CI,
    output logic             BUSY,
    output logic             TC,
    output logic             DONE
);

    logic             w_rst_n;
    cnt_state_e       r_state;
    cnt_state_e       w_next_state;
    logic [WIDTH-1:0] r_reload;
    logic             r_mode;
    logic             r_tc;
    logic             r_live;
    logic             w_term;
    logic             w_start;

    // The device-wide set/reset is mapped by the tool onto the CDN flop pins,
    // so in RTL both configurations share the single reset net.
    if (GSR == "ENABLED") begin : g_gsr_on
        assign w_rst_n = CDN;
    end else begin : g_gsr_off
        assign w_rst_n = CDN;
    end

    always_comb begin
        w_term       = (r_state == StRun) && !HOLD && CNT_CO;
        // r_live blocks START on the first edge after reset release.
        w_start      = START && r_live && (r_state != StLoad);
        w_next_state = r_state;
        CNT_SP       = 1'b0;
        CNT_SD       = 1'b0;
        CNT_CI       = 1'b0;
        unique case (r_state)
            StIdle: ;
            StLoad: begin
                CNT_SP       = 1'b1;
                CNT_SD       = 1'b1;
                w_next_state = StRun;
            end
            StRun: begin
                CNT_SP = !HOLD;
                CNT_CI = !HOLD;
                CNT_SD = w_term && (r_mode == MODE_PERIODIC);
                if (w_term && (r_mode == MODE_ONESHOT)) begin
                    w_next_state = StDone;
                end
            end
            StDone: ;
            default: w_next_state = StIdle;
        endcase
        if (w_start) begin
            w_next_state = StLoad;
        end
        if (STOP) begin
            w_next_state = StIdle;
        end
    end

    always_ff @(posedge CK or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state  <= StIdle;
            r_reload <= '0;
            r_mode   <= MODE_ONESHOT;
            r_tc     <= 1'b0;
            r_live   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_tc    <= w_term;
            r_live  <= 1'b1;
            if (w_start && !STOP) begin
                r_reload <= RELOAD;
                r_mode   <= MODE;
            end
        end
    end

    assign CNT_D = r_reload;
    assign TC    = r_tc;
    assign BUSY  = (r_state == StLoad) || (r_state == StRun);
    assign DONE  = (r_state == StDone);

endmodule

// File: doc/cnt_seq_ctrl.md
CNT_SEQ_CTRL -- requirements
Module: cnt_seq_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, meaning: counter datapath width in bits; SHALL be even, 2..32.
REQ-002 Parameter GSR, default "ENABLED", meaning: "ENABLED" lets global set/reset clear the block like CDN; "DISABLED" leaves only CDN.
REQ-003 CK  input  1  sole clock; all state updates on rising edge.
REQ-004 CDN  input  1  asynchronous active-low reset.
REQ-005 START  input  1  one-cycle request to load RELOAD and begin counting.
REQ-006 STOP  input  1  one-cycle request to abort and return to idle.
REQ-007 MODE  input  1  0 = one-shot, 1 = periodic; sampled with START.
REQ-008 HOLD  input  1  pauses counting while high in RUN.
REQ-009 RELOAD  input  WIDTH  start value; sampled with START.
REQ-010 CNT_CO  input  1  carry-out from top datapath slice.
REQ-011 CNT_D  output  WIDTH  load data to datapath.
REQ-012 CNT_SD  output  1  datapath load select: 1 = load CNT_D, 0 = count.
REQ-013 CNT_SP  output  1  datapath clock enable.
REQ-014 CNT_CI  output  1  datapath carry-in.
REQ-015 BUSY  output  1  high in LOAD or RUN.
REQ-016 TC  output  1  registered one-cycle terminal-count pulse.
REQ-017 DONE  output  1  high in DONE state.

Function
REQ-018 FSM states IDLE, LOAD, RUN, DONE; encoding from shared package.
REQ-019 IDLE: CNT_SP=CNT_SD=CNT_CI=0; START -> LOAD.
REQ-020 START in IDLE, DONE or RUN SHALL capture RELOAD and MODE into registers; CNT_D always drives the captured reload register.
REQ-021 LOAD (exactly one cycle): CNT_SP=1, CNT_SD=1, CNT_CI=0; -> RUN.
REQ-022 RUN: CNT_SP=~HOLD, CNT_CI=~HOLD, CNT_SD=0 except REQ-024.
REQ-023 Terminal event = RUN & ~HOLD & CNT_CO; TC SHALL be high in the cycle after each terminal event.
REQ-024 Periodic mode: on terminal event CNT_SD SHALL be 1 combinationally in that cycle so the same edge reloads; stay RUN; period = 2^WIDTH - RELOAD cycles.
REQ-025 One-shot mode: terminal edge lets datapath wrap to 0; -> DONE; CNT_SP=0 in DONE.
REQ-026 DONE: START -> LOAD; otherwise hold.
REQ-027 STOP SHALL win over START and terminal event in any state: next state IDLE; TC still reported for a coincident terminal event.
REQ-028 START in RUN without STOP SHALL restart (-> LOAD), overriding a coincident terminal event's next-state while still pulsing TC.
REQ-029 RELOAD all-ones: terminal event in first RUN cycle (period 1 in periodic mode).
REQ-030 HOLD SHALL mask CNT_CO; no terminal event while HOLD=1.

Reset
REQ-031 CDN low SHALL asynchronously force IDLE, reload/mode registers 0, and all outputs 0 (CNT_D=0, TC=0, DONE=0, BUSY=0).
REQ-032 Reset deassertion SHALL take effect synchronously at first CK edge with CDN high; no START accepted in that same cycle.
REQ-033 With GSR="ENABLED", global reset SHALL act identically to CDN.

Structure
REQ-034 Shared package cnt_seq_pkg SHALL hold state encodings and MODE_ONESHOT/MODE_PERIODIC constants.
REQ-035 Single module, no sub-modules; datapath external; only CNT_SD may depend combinationally on CNT_CO.

Verification (WIDTH=8)
REQ-036 CDN pulsed low mid-RUN -> all outputs 0 immediately, IDLE after release.
REQ-037 One-shot RELOAD=0xFA, START cycle 0 -> LOAD cycle 1, RUN cycles 2-7, CNT_CO at Q=0xFF in cycle 7, TC cycle 8, DONE=1 from cycle 8, Q=0x00.
REQ-038 Periodic RELOAD=0xFD -> TC every 3 cycles, Q sequence FD,FE,FF,FD..., CNT_SD=1 only on Q=0xFF cycles.
REQ-039 One-shot RELOAD=0xFA, HOLD high cycles 4-7 -> TC delayed to cycle 12, Q frozen during hold.
REQ-040 START and STOP same cycle in RUN -> IDLE next cycle, CNT_SP=0, no LOAD.
REQ-041 Periodic RELOAD=0xFF -> TC every cycle; START with RELOAD=0xF0 at a terminal event -> TC pulse, LOAD with 0xF0.
